// File: rtl/agg_core_pkg.sv
// agg_core_pkg -- shared definitions for the aggregation core.
//   NUM          : element magnitude width; elements are NUM+1 bits signed.
//   EW           : element width (NUM+1).
//   agg_state_t  : aggregation FSM state (ACCUM, EMIT).
//   cnt_w()      : width of the result count field for a given window size,
//                  wide enough to hold the value WIN itself.
package agg_core_pkg;

  localparam int NUM = 7;
  localparam int EW  = NUM + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } agg_state_t;

  function automatic int cnt_w(input int win);
    return $clog2(win) + 1;
  endfunction

endpackage

// File: rtl/agg_core_if.sv
// agg_core_if -- element input and result output bundle of agg_core.
//   Upstream  : cdata (signed EW), cvalid, cflush -> core; cstop <- core.
//   Downstream: osum (signed SW), ocount, ovalid, [omin, omax] <- core;
//               ostop -> core.
//   omin/omax exist only when AGG_MINMAX_EN is defined.
//   Modports: slave = core side, master = environment side.
//
// Handshake: an element transfers on a rising edge where cvalid && !cstop;
// a result transfers on a rising edge where ovalid && !ostop. A producer
// holds its payload stable while it is valid and not yet taken.
interface agg_core_if
  import agg_core_pkg::*;
#(
  parameter int WIN = 16,
  parameter int SW  = NUM + 1 + $clog2(WIN)
);
  localparam int CW = cnt_w(WIN);

  logic [EW-1:0] cdata;
  logic          cvalid;
  logic          cflush;
  logic          cstop;

  logic [SW-1:0] osum;
  logic [CW-1:0] ocount;
  logic          ovalid;
  logic          ostop;
`ifdef AGG_MINMAX_EN
  logic [EW-1:0] omin;
  logic [EW-1:0] omax;
`endif

  modport slave (
    input  cdata, cvalid, cflush, ostop,
    output cstop, osum, ocount, ovalid
`ifdef AGG_MINMAX_EN
    , output omin, omax
`endif
  );

  modport master (
    output cdata, cvalid, cflush, ostop,
    input  cstop, osum, ocount, ovalid
`ifdef AGG_MINMAX_EN
    , input omin, omax
`endif
  );

endinterface

// File: rtl/agg_minmax.sv
// agg_minmax -- running signed minimum/maximum of a window.
//   clk, reset (async active-low)
//   clr   : clear both registers to 0 (window consumed)
//   upd   : an element is accepted this cycle
//   first : the accepted element is the first of its window (load directly)
//   din   : signed element
//   mn/mx : current signed minimum / maximum
module agg_minmax
  import agg_core_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          upd,
  input  logic          first,
  input  logic [EW-1:0] din,
  output logic [EW-1:0] mn,
  output logic [EW-1:0] mx
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mn <= '0;
      mx <= '0;
    end else if (clr) begin
      mn <= '0;
      mx <= '0;
    end else if (upd) begin
      if (first || ($signed(din) < $signed(mn))) mn <= din;
      if (first || ($signed(din) > $signed(mx))) mx <= din;
    end
  end

endmodule

// File: rtl/agg_core.sv
// agg_core -- windowed signed aggregation (sum, count, optional min/max).
//   Parameters: WIN (window size, power of two 2..1024), SW (sum width).
//   clk       : clock, all state on rising edge
//   reset     : asynchronous active-low reset
//   bus       : agg_core_if.slave (element in, result out)
//   dbg_state : current FSM state
// Optional feature: define AGG_MINMAX_EN to add omin/omax tracking.
// Elements are summed until WIN are taken or an accepted element carries
// cflush; the result is then held in EMIT until consumed, during which the
// input is stalled (cstop) so the accumulators stay stable as the payload.
module agg_core
  import agg_core_pkg::*;
#(
  parameter int WIN = 16,
  parameter int SW  = NUM + 1 + $clog2(WIN)
)(
  input  logic        clk,
  input  logic        reset,
  agg_core_if.slave   bus,
  output agg_state_t  dbg_state
);

  localparam int CW = cnt_w(WIN);

  agg_state_t    state_q, state_d;
  logic [SW-1:0] sum_q;
  logic [CW-1:0] count_q;
  logic          accept;
  logic          consume;
  logic          close_win;

  // cstop is a pure state decode, so acceptance only needs cvalid and state.
  assign accept    = bus.cvalid && (state_q == ACCUM);
  assign consume   = (state_q == EMIT) && !bus.ostop;
  assign close_win = accept && (bus.cflush || (count_q == CW'(WIN - 1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (close_win) state_d = EMIT;
      EMIT:    if (consume)   state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      count_q <= '0;
    end else if (consume) begin
      sum_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      sum_q   <= sum_q + {{(SW - EW){bus.cdata[EW-1]}}, bus.cdata};
      count_q <= count_q + CW'(1);
    end
  end

  assign bus.cstop  = (state_q == EMIT);
  assign bus.ovalid = (state_q == EMIT);
  assign bus.osum   = sum_q;
  assign bus.ocount = count_q;
  assign dbg_state  = state_q;

`ifdef AGG_MINMAX_EN
  agg_minmax u_minmax (
    .clk   (clk),
    .reset (reset),
    .clr   (consume),
    .upd   (accept),
    .first (count_q == '0),
    .din   (bus.cdata),
    .mn    (bus.omin),
    .mx    (bus.omax)
  );
`endif

endmodule

// File: tb/tb_agg_core.sv
// tb_agg_core -- directed self-checking bench for agg_core with WIN=4.
module tb_agg_core;
  import agg_core_pkg::*;

  localparam int WIN = 4;
  localparam int SW  = NUM + 1 + $clog2(WIN);
  localparam int CW  = cnt_w(WIN);

  logic       clk;
  logic       reset;
  agg_state_t dbg_state;
  int         checks;
  int         errors;

  agg_core_if #(.WIN(WIN), .SW(SW)) bus ();

  agg_core #(.WIN(WIN), .SW(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present an element and wait (bounded) until it is accepted.
  // Returns at posedge+1 of the accepting edge.
  task automatic send(input logic [EW-1:0] d, input logic f);
    logic acc;
    acc = 1'b0;
    bus.cvalid = 1'b1;
    bus.cdata  = d;
    bus.cflush = f;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = !bus.cstop;
      @(posedge clk);
      #1;
    end
    bus.cvalid = 1'b0;
    bus.cflush = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_accept got timeout exp accepted data %0d", $signed(d));
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.cstop !== 1'b0) begin errors++; $display("FAIL rst_cstop got %b exp 0", bus.cstop); end
    checks++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL rst_ovalid got %b exp 0", bus.ovalid); end
    checks++; if (bus.osum !== SW'(0)) begin errors++; $display("FAIL rst_osum got %0d exp 0", $signed(bus.osum)); end
    checks++; if (bus.ocount !== CW'(0)) begin errors++; $display("FAIL rst_ocount got %0d exp 0", bus.ocount); end
    checks++; if (dbg_state !== ACCUM) begin errors++; $display("FAIL rst_state got %0d exp ACCUM", dbg_state); end
`ifdef AGG_MINMAX_EN
    checks++; if (bus.omin !== EW'(0) || bus.omax !== EW'(0)) begin
      errors++; $display("FAIL rst_minmax got %0d/%0d exp 0/0", $signed(bus.omin), $signed(bus.omax));
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bus.ostop = 1'b0;
    send(EW'(3), 1'b0);
    send(EW'(-5), 1'b0);
    send(EW'(7), 1'b0);
    checks++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL basic_early_ovalid got %b exp 0", bus.ovalid); end
    checks++; if (bus.ocount !== CW'(3)) begin errors++; $display("FAIL basic_partial_count got %0d exp 3", bus.ocount); end
    send(EW'(1), 1'b0);
    checks++; if (bus.ovalid !== 1'b1) begin errors++; $display("FAIL basic_ovalid got %b exp 1", bus.ovalid); end
    checks++; if (bus.cstop !== 1'b1) begin errors++; $display("FAIL basic_cstop got %b exp 1", bus.cstop); end
    checks++; if (bus.osum !== SW'(6)) begin errors++; $display("FAIL basic_osum got %0d exp 6", $signed(bus.osum)); end
    checks++; if (bus.ocount !== CW'(4)) begin errors++; $display("FAIL basic_ocount got %0d exp 4", bus.ocount); end
`ifdef AGG_MINMAX_EN
    checks++; if (bus.omin !== EW'(-5)) begin errors++; $display("FAIL basic_omin got %0d exp -5", $signed(bus.omin)); end
    checks++; if (bus.omax !== EW'(7)) begin errors++; $display("FAIL basic_omax got %0d exp 7", $signed(bus.omax)); end
`endif
    @(posedge clk);
    #1;
    checks++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL basic_consumed got %b exp 0", bus.ovalid); end
    checks++; if (bus.ocount !== CW'(0)) begin errors++; $display("FAIL basic_cleared got %0d exp 0", bus.ocount); end
  endtask

  task automatic test_flush();
    bus.cflush = 1'b1;
    bus.cvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.cflush = 1'b0;
    checks++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL flush_novalid got %b exp 0", bus.ovalid); end
    checks++; if (bus.ocount !== CW'(0)) begin errors++; $display("FAIL flush_nocount got %0d exp 0", bus.ocount); end
    send(EW'(10), 1'b0);
    send(EW'(20), 1'b1);
    checks++; if (bus.ovalid !== 1'b1) begin errors++; $display("FAIL flush_ovalid got %b exp 1", bus.ovalid); end
    checks++; if (bus.osum !== SW'(30)) begin errors++; $display("FAIL flush_osum got %0d exp 30", $signed(bus.osum)); end
    checks++; if (bus.ocount !== CW'(2)) begin errors++; $display("FAIL flush_ocount got %0d exp 2", bus.ocount); end
`ifdef AGG_MINMAX_EN
    checks++; if (bus.omin !== EW'(10)) begin errors++; $display("FAIL flush_omin got %0d exp 10", $signed(bus.omin)); end
    checks++; if (bus.omax !== EW'(20)) begin errors++; $display("FAIL flush_omax got %0d exp 20", $signed(bus.omax)); end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_negative();
    for (int i = 0; i < 4; i++) send(EW'(-128), 1'b0);
    checks++; if (bus.ovalid !== 1'b1) begin errors++; $display("FAIL neg_ovalid got %b exp 1", bus.ovalid); end
    checks++; if (bus.osum !== SW'(-512)) begin errors++; $display("FAIL neg_osum got %0d exp -512", $signed(bus.osum)); end
`ifdef AGG_MINMAX_EN
    checks++; if (bus.omin !== EW'(-128) || bus.omax !== EW'(-128)) begin
      errors++; $display("FAIL neg_minmax got %0d/%0d exp -128/-128", $signed(bus.omin), $signed(bus.omax));
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    bus.ostop = 1'b1;
    send(EW'(1), 1'b0);
    send(EW'(2), 1'b0);
    send(EW'(3), 1'b0);
    send(EW'(4), 1'b0);
    bus.cvalid = 1'b1;
    bus.cdata  = EW'(9);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.cstop !== 1'b1 || bus.ovalid !== 1'b1 || bus.osum !== SW'(10) || bus.ocount !== CW'(4)) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got cstop %b ovalid %b osum %0d ocount %0d exp 1 1 10 4",
                 i, bus.cstop, bus.ovalid, $signed(bus.osum), bus.ocount);
      end
      @(posedge clk);
      #1;
    end
    bus.ostop = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ovalid !== 1'b0 || bus.cstop !== 1'b0 || bus.ocount !== CW'(0)) begin
      errors++;
      $display("FAIL stall_consume got ovalid %b cstop %b ocount %0d exp 0 0 0", bus.ovalid, bus.cstop, bus.ocount);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.ocount !== CW'(1) || bus.osum !== SW'(9)) begin
      errors++; $display("FAIL stall_accept9 got ocount %0d osum %0d exp 1 9", bus.ocount, $signed(bus.osum));
    end
    bus.cvalid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.ocount !== CW'(1)) begin errors++; $display("FAIL stall_once got %0d exp 1", bus.ocount); end
    send(EW'(1), 1'b0);
    send(EW'(1), 1'b0);
    send(EW'(1), 1'b0);
    checks++;
    if (bus.ovalid !== 1'b1 || bus.osum !== SW'(12) || bus.ocount !== CW'(4)) begin
      errors++; $display("FAIL stall_next_win got ovalid %b osum %0d ocount %0d exp 1 12 4",
                         bus.ovalid, $signed(bus.osum), bus.ocount);
    end
`ifdef AGG_MINMAX_EN
    checks++; if (bus.omin !== EW'(1) || bus.omax !== EW'(9)) begin
      errors++; $display("FAIL stall_minmax got %0d/%0d exp 1/9", $signed(bus.omin), $signed(bus.omax));
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    send(EW'(5), 1'b0);
    send(EW'(6), 1'b0);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.cstop !== 1'b0 || bus.ovalid !== 1'b0 || bus.ocount !== CW'(0) || bus.osum !== SW'(0)) begin
      errors++; $display("FAIL rstmid_win got cstop %b ovalid %b ocount %0d osum %0d exp 0 0 0 0",
                         bus.cstop, bus.ovalid, bus.ocount, $signed(bus.osum));
    end
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.ostop = 1'b1;
    for (int i = 0; i < 4; i++) send(EW'(2), 1'b0);
    checks++; if (bus.ovalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_emit got %b exp 1", bus.ovalid); end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.cstop !== 1'b0 || bus.ovalid !== 1'b0 || bus.ocount !== CW'(0)) begin
      errors++; $display("FAIL rstmid_emit got cstop %b ovalid %b ocount %0d exp 0 0 0",
                         bus.cstop, bus.ovalid, bus.ocount);
    end
    #1;
    reset = 1'b1;
    bus.ostop = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(EW'(1), 1'b0);
    checks++;
    if (bus.ovalid !== 1'b1 || bus.osum !== SW'(4) || bus.ocount !== CW'(4)) begin
      errors++; $display("FAIL rstmid_after got ovalid %b osum %0d ocount %0d exp 1 4 4",
                         bus.ovalid, $signed(bus.osum), bus.ocount);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    bus.cvalid = 1'b0;
    bus.cdata  = '0;
    bus.cflush = 1'b0;
    bus.ostop  = 1'b0;
    test_reset();
    test_basic();
    test_flush();
    test_negative();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard time bound in case a task stalls on the clock
  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/agg_core.md
AGG_CORE -- requirements
Module: agg_core

Interface
REQ-001 Parameter WIN, default 16: elements per aggregation window, power of two, 2..1024.
REQ-002 Parameter SW, default NUM+1+$clog2(WIN): sum width (NUM comes from the shared package).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-005 cdata  input  NUM+1  signed element from upstream skid buffer.
REQ-006 cvalid  input  1  cdata valid.
REQ-007 cstop  output  1  backpressure to upstream; element accepted iff cvalid && !cstop at a rising edge.
REQ-008 cflush  input  1  sampled only with an accepted element; closes the window early, element included.
REQ-009 osum  output  SW  signed window sum.
REQ-010 omin / omax  output  NUM+1 each  signed window minimum / maximum (present only with AGG_MINMAX_EN).
REQ-011 ocount  output  $clog2(WIN)+1  elements in emitted window, 1..WIN.
REQ-012 ovalid  output  1  result valid; held with stable payload until consumed.
REQ-013 ostop  input  1  downstream backpressure; result consumed iff ovalid && !ostop at a rising edge.

Function
REQ-014 FSM has two states, ACCUM and EMIT; cstop = (state==EMIT), ovalid = (state==EMIT), both Moore decodes, no combinational path from ostop or cvalid to cstop.
REQ-015 ACCUM, per accepted element: sum += sign-extended cdata; count += 1; min/max updated by signed compare (first element of a window loads min and max directly).
REQ-016 ACCUM -> EMIT on the edge accepting the element that makes count==WIN, or any accepted element with cflush=1; outputs carry totals including that element.
REQ-017 Latency: ovalid rises the cycle after the closing element is accepted; minimum window cycle WIN+1 clocks with ostop=0.
REQ-018 EMIT -> ACCUM on the consume edge; accumulators and count clear on that same edge; first element is accepted no earlier than the next cycle.
REQ-019 In EMIT, osum/omin/omax/ocount are stable while ostop=1; cdata/cvalid/cflush are ignored.
REQ-020 cflush with cvalid=0, or while in EMIT, has no effect; no empty (count 0) result is ever emitted.
REQ-021 Sum never overflows: SW covers WIN elements at full-scale negative (-2^NUM * WIN).
REQ-022 cvalid=1 held with unchanged cdata across EMIT is accepted exactly once, after EMIT exits.

Reset
REQ-023 While reset=0: state=ACCUM, cstop=0, ovalid=0, sum=0, count=0, min=0, max=0, ocount=0.
REQ-024 Reset mid-window or mid-EMIT discards the partial window/pending result; first accepted element after release starts a new window.

Configuration
REQ-025 Macro AGG_MINMAX_EN defined: omin/omax ports, registers and comparators exist per REQ-015.
REQ-026 AGG_MINMAX_EN undefined: omin/omax ports and logic are absent; sum/count/handshake timing identical.

Structure
REQ-027 Shared package holds NUM, the FSM state enum (ACCUM, EMIT) and the result-width helper constant.
REQ-028 One sub-module agg_minmax (signed compare/update of min/max, first-element load), instantiated only under AGG_MINMAX_EN.

Verification
REQ-029 WIN=4, NUM=7, ostop=0, elements 3,-5,7,1 back-to-back -> ovalid one cycle after 4th accept, osum=6, omin=-5, omax=7, ocount=4.
REQ-030 Elements 10,20 with cflush=1 on 20 -> osum=30, ocount=2, omin=10, omax=20; cflush with cvalid=0 earlier -> no emit.
REQ-031 WIN=4, four elements of -128 -> osum=-512 (no overflow), omin=omax=-128.
REQ-032 ostop=1 for 5 cycles during EMIT, cvalid held with 9 -> cstop=1, payload stable for 5 cycles, 9 accepted once after consume, becomes first of next window.
REQ-033 reset=0 asserted between clock edges after 2 accepted elements -> cstop/ovalid drop immediately; after release, 4 new elements 1,1,1,1 -> osum=4.
REQ-034 Build without AGG_MINMAX_EN, rerun REQ-029 -> osum=6, ocount=4, identical cycle timing.
